// File: rtl/ghost_filter.sv
// Purpose : temporal ghost suppression of the two per-BX track candidates from the collider.
// Latency : 2 cycles, input -> S1 register -> compare against history -> output register.
// Flow    : no backpressure; one BX per cycle is accepted and produced unconditionally.
//
// Ports
//   clk_i, rst_i          clock (one BX per cycle), synchronous active-high reset
//   en_i                  1 = filtering active, 0 = transparent (history still updated)
//   cnt_clr_i             synchronous clear of ghost_cnt_o (wins over increment)
//   w1_i/q1_i/v1_i        candidate 1 key (0..47), quality, valid
//   w2_i/q2_i/v2_i        candidate 2 key (0..47), quality, valid
//   tw*_o/tq*_o/tv*_o     accepted tracks, compacted into slot 1 first
//   ghost_o               one-cycle pulse when any candidate was suppressed
//   ghost_cnt_o           saturating count of suppressed candidates
//
// Build option: define GHOST_NEIGHBOUR_EN to also match history keys at w-1 / w+1.

module ghost_filter #(
  parameter int DEAD_BX = 3,   // suppression window in BX, 1..7
  parameter int CNT_W   = 16   // ghost counter width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cnt_clr_i,
  input  logic [6:0]       w1_i,
  input  logic [6:0]       w2_i,
  input  logic [1:0]       q1_i,
  input  logic [1:0]       q2_i,
  input  logic             v1_i,
  input  logic             v2_i,
  output logic [6:0]       tw1_o,
  output logic [6:0]       tw2_o,
  output logic [1:0]       tq1_o,
  output logic [1:0]       tq2_o,
  output logic             tv1_o,
  output logic             tv2_o,
  output logic             ghost_o,
  output logic [CNT_W-1:0] ghost_cnt_o
);

  typedef struct packed {
    logic       vld;
    logic [6:0] key;
    logic [1:0] q;
  } trk_t;

  localparam logic [6:0] KEY_NONE = 7'h7f;  // reserved key, never matches
  localparam logic [6:0] KEY_MAX  = 7'd47;

  trk_t [1:0]              s1_q, s1_d;
  trk_t [1:0]              out_q, out_d;
  trk_t [DEAD_BX-1:0][1:0] hist_q, hist_d;
  logic                    ghost_q, ghost_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [1:0]              sup;
  logic [1:0]              pass;
  logic [1:0]              n_sup;
  logic [CNT_W:0]          cnt_sum;

  // Key match between a history entry and a candidate. Neighbour terms are
  // guarded so keys never wrap (0 has no -1, 47 and above have no +1).
  function automatic logic key_hit(input logic [6:0] h, input logic [6:0] w);
    logic hit;
    hit = (h == w);
`ifdef GHOST_NEIGHBOUR_EN
    hit = hit | ((w != 7'd0) && (h == (w - 7'd1)));
    hit = hit | ((w < KEY_MAX) && (h == (w + 7'd1)));
`endif
    return hit && (w != KEY_NONE) && (h != KEY_NONE);
  endfunction

  always_comb begin
    // Stage-1 capture: invalid candidates are stored as all-zero so their
    // key/quality can never leak into compare or output.
    s1_d[0] = v1_i ? trk_t'{vld: 1'b1, key: w1_i, q: q1_i} : trk_t'('0);
    s1_d[1] = v2_i ? trk_t'{vld: 1'b1, key: w2_i, q: q2_i} : trk_t'('0);
  end

  always_comb begin
    sup = '0;
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < DEAD_BX; s++) begin
        for (int e = 0; e < 2; e++) begin
          if (en_i && s1_q[i].vld && hist_q[s][e].vld &&
              key_hit(hist_q[s][e].key, s1_q[i].key) &&
              (hist_q[s][e].q >= s1_q[i].q)) begin
            sup[i] = 1'b1;
          end
        end
      end
      pass[i] = s1_q[i].vld & ~sup[i];
    end

    // Compaction: a lone survivor always lands in slot 1.
    out_d = '0;
    if (pass[0]) begin
      out_d[0] = s1_q[0];
      if (pass[1]) out_d[1] = s1_q[1];
    end else if (pass[1]) begin
      out_d[0] = s1_q[1];
    end

    // Accepted tracks enter the youngest stage; everything else ages by one.
    hist_d[0] = out_d;
    for (int s = 1; s < DEAD_BX; s++) begin
      hist_d[s] = hist_q[s-1];
    end

    ghost_d = |sup;

    n_sup   = {1'b0, sup[0]} + {1'b0, sup[1]};
    cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, n_sup};
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_sum[CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= '0;
      out_q   <= '0;
      hist_q  <= '0;
      ghost_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      out_q   <= out_d;
      hist_q  <= hist_d;
      ghost_q <= ghost_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tw1_o       = out_q[0].key;
  assign tq1_o       = out_q[0].q;
  assign tv1_o       = out_q[0].vld;
  assign tw2_o       = out_q[1].key;
  assign tq2_o       = out_q[1].q;
  assign tv2_o       = out_q[1].vld;
  assign ghost_o     = ghost_q;
  assign ghost_cnt_o = cnt_q;

endmodule

// File: tb/tb_ghost_filter.sv
// Directed bench for ghost_filter (DEAD_BX=3, CNT_W=16).
// Each step drives one BX, waits for the rising edge, and samples 1 time unit later,
// so the outputs seen after driving BX k belong to BX k-1.

module tb_ghost_filter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cnt_clr;
  logic [6:0]  w1, w2, tw1, tw2;
  logic [1:0]  q1, q2, tq1, tq2;
  logic        v1, v2, tv1, tv2;
  logic        ghost;
  logic [15:0] ghost_cnt;

  int nvec  = 0;
  int nfail = 0;
  int exp_cnt = 0;

  ghost_filter #(.DEAD_BX(3), .CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .cnt_clr_i   (cnt_clr),
    .w1_i        (w1),
    .w2_i        (w2),
    .q1_i        (q1),
    .q2_i        (q2),
    .v1_i        (v1),
    .v2_i        (v2),
    .tw1_o       (tw1),
    .tw2_o       (tw2),
    .tq1_o       (tq1),
    .tq2_o       (tq2),
    .tv1_o       (tv1),
    .tv2_o       (tv2),
    .ghost_o     (ghost),
    .ghost_cnt_o (ghost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drv(input logic [6:0] a, input logic [1:0] qa, input logic va,
                     input logic [6:0] b, input logic [1:0] qb, input logic vb);
    w1 = a; q1 = qa; v1 = va;
    w2 = b; q2 = qb; v2 = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(7'd0, 2'd0, 1'b0, 7'd0, 2'd0, 1'b0);
  endtask

  task automatic flush();
    repeat (4) idle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cnt_clr = 1'b0;
    w1 = '0; w2 = '0; q1 = '0; q2 = '0; v1 = 1'b0; v2 = 1'b0;

    // Reset with random inputs
    repeat (2) drv(7'($urandom), 2'($urandom), 1'($urandom),
                   7'($urandom), 2'($urandom), 1'($urandom));
    chk("rst_tv1", tv1, 0);
    chk("rst_tv2", tv2, 0);
    chk("rst_tw1", tw1, 0);
    chk("rst_tw2", tw2, 0);
    chk("rst_tq1", tq1, 0);
    chk("rst_tq2", tq2, 0);
    chk("rst_ghost", ghost, 0);
    chk("rst_cnt", ghost_cnt, 0);
    rst = 1'b0;

    // Repeat of key 20 q2 for 5 BX: BX0 and BX4 pass, BX1..3 suppressed
    drv(7'd20, 2'd2, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("lat_tv1", tv1, 0);
    drv(7'd20, 2'd2, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("rep0_tv1", tv1, 1);
    chk("rep0_tw1", tw1, 20);
    chk("rep0_ghost", ghost, 0);
    drv(7'd20, 2'd2, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("rep1_tv1", tv1, 0);
    chk("rep1_tw1", tw1, 0);
    chk("rep1_ghost", ghost, 1);
    drv(7'd20, 2'd2, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("rep2_ghost", ghost, 1);
    drv(7'd20, 2'd2, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("rep3_tv1", tv1, 0);
    chk("rep3_ghost", ghost, 1);
    idle();
    chk("rep4_tv1", tv1, 1);
    chk("rep4_tw1", tw1, 20);
    chk("rep4_ghost", ghost, 0);
    exp_cnt = 3;
    chk("rep_cnt", ghost_cnt, 32'(exp_cnt));
    flush();

    // Quality upgrade: q1 then q3 pass, second q3 suppressed
    drv(7'd10, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    drv(7'd10, 2'd3, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("qup0_tv1", tv1, 1);
    chk("qup0_tq1", tq1, 1);
    drv(7'd10, 2'd3, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("qup1_tv1", tv1, 1);
    chk("qup1_tq1", tq1, 3);
    chk("qup1_ghost", ghost, 0);
    idle();
    chk("qup2_tv1", tv1, 0);
    chk("qup2_ghost", ghost, 1);
    exp_cnt = 4;
    chk("qup_cnt", ghost_cnt, 32'(exp_cnt));
    flush();

    // Compaction: cand1 suppressed, cand2 moves to slot 1
    drv(7'd5, 2'd1, 1'b1, 7'd9, 2'd0, 1'b1);
    drv(7'd5, 2'd1, 1'b1, 7'd30, 2'd2, 1'b1);
    chk("cmp0_tw1", tw1, 5);
    chk("cmp0_tv2", tv2, 1);
    chk("cmp0_tw2", tw2, 9);
    idle();
    chk("cmp1_tv1", tv1, 1);
    chk("cmp1_tw1", tw1, 30);
    chk("cmp1_tq1", tq1, 2);
    chk("cmp1_tv2", tv2, 0);
    chk("cmp1_tw2", tw2, 0);
    chk("cmp1_ghost", ghost, 1);
    exp_cnt = 5;
    chk("cmp_cnt", ghost_cnt, 32'(exp_cnt));
    flush();

    // Same key twice in one BX: never compared with each other
    drv(7'd40, 2'd1, 1'b1, 7'd40, 2'd1, 1'b1);
    idle();
    chk("same_tv1", tv1, 1);
    chk("same_tv2", tv2, 1);
    chk("same_tw2", tw2, 40);
    chk("same_ghost", ghost, 0);
    flush();

    // Invalid cand1 ignored; valid cand2 fills slot 1 and enters history
    drv(7'd12, 2'd3, 1'b0, 7'd12, 2'd0, 1'b1);
    drv(7'd12, 2'd0, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("inv0_tv1", tv1, 1);
    chk("inv0_tw1", tw1, 12);
    chk("inv0_tq1", tq1, 0);
    chk("inv0_tv2", tv2, 0);
    idle();
    chk("inv1_tv1", tv1, 0);
    chk("inv1_ghost", ghost, 1);
    exp_cnt = 6;
    flush();

    // Key 7f never matches
    drv(7'h7f, 2'd0, 1'b1, 7'd0, 2'd0, 1'b0);
    drv(7'h7f, 2'd0, 1'b1, 7'd0, 2'd0, 1'b0);
    idle();
    chk("k7f_tv1", tv1, 1);
    chk("k7f_tw1", tw1, 32'h7f);
    chk("k7f_ghost", ghost, 0);
    flush();

    // Transparent mode still fills history; re-enabling suppresses the repeat
    en = 1'b0;
    drv(7'd33, 2'd2, 1'b1, 7'd0, 2'd0, 1'b0);
    drv(7'd33, 2'd2, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("en0_tv1", tv1, 1);
    idle();
    chk("en1_tv1", tv1, 1);
    chk("en1_ghost", ghost, 0);
    chk("en1_cnt", ghost_cnt, 32'(exp_cnt));
    en = 1'b1;
    drv(7'd33, 2'd2, 1'b1, 7'd0, 2'd0, 1'b0);
    idle();
    chk("en2_tv1", tv1, 0);
    chk("en2_ghost", ghost, 1);
    exp_cnt = 7;
    chk("en_cnt", ghost_cnt, 32'(exp_cnt));
    flush();

    // Neighbour key 0 then key 1
    drv(7'd0, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    drv(7'd1, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    idle();
`ifdef GHOST_NEIGHBOUR_EN
    chk("nb_tv1", tv1, 0);
    chk("nb_ghost", ghost, 1);
    exp_cnt = 8;
`else
    chk("nb_tv1", tv1, 1);
    chk("nb_tw1", tw1, 1);
    chk("nb_ghost", ghost, 0);
`endif
    chk("nb_cnt", ghost_cnt, 32'(exp_cnt));
    flush();

    // Key 47 followed by key 0: no wrap-around match
    drv(7'd47, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    drv(7'd0, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    idle();
    chk("wrap_tv1", tv1, 1);
    chk("wrap_tw1", tw1, 0);
    chk("wrap_ghost", ghost, 0);
    flush();

    // Mid-stream reset discards S1, history and counter
    drv(7'd44, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    idle();
    chk("mrst0_tv1", tv1, 1);
    rst = 1'b1;
    drv(7'd44, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("mrst1_tv1", tv1, 0);
    chk("mrst1_tw1", tw1, 0);
    chk("mrst1_cnt", ghost_cnt, 0);
    rst = 1'b0;
    drv(7'd44, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("mrst2_tv1", tv1, 0);
    idle();
    chk("mrst3_tv1", tv1, 1);
    chk("mrst3_ghost", ghost, 0);
    exp_cnt = 0;
    flush();

    // Saturation: 6 suppressions per 4 BX, 66000 in total
    for (int p = 0; p < 11000; p++) begin
      repeat (4) drv(7'd20, 2'd2, 1'b1, 7'd20, 2'd2, 1'b1);
    end
    flush();
    chk("sat_cnt", ghost_cnt, 32'hffff);

    // Clear together with a ghost gives zero
    drv(7'd25, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    drv(7'd25, 2'd1, 1'b1, 7'd0, 2'd0, 1'b0);
    chk("sat_hold", ghost_cnt, 32'hffff);
    cnt_clr = 1'b1;
    idle();
    chk("clr_ghost", ghost, 1);
    chk("clr_cnt", ghost_cnt, 0);
    cnt_clr = 1'b0;
    idle();
    chk("clr_after", ghost_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
